// File: rtl/bi_deser.sv
// Serial-to-parallel receiver: gathers WIDTH bits LSB- or MSB-first and
// offers the assembled word on a one-entry valid/ready output register.
module bi_deser #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic             in_valid,
  input  logic             dir,
  input  logic             flush,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [CW-1:0]    bit_cnt,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic {
    S_IDLE,
    S_COLLECT
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_asm;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_outData;
  logic             r_outValid;
  logic             r_overrun;

  state_t           w_stateNext;
  logic [WIDTH-1:0] w_asmNext;
  logic [CW-1:0]    w_cntNext;
  logic             w_dirNext;
  logic [WIDTH-1:0] w_outDataNext;
  logic             w_outValidNext;
  logic             w_overrunNext;
  logic             w_dirEff;
  logic [WIDTH-1:0] w_shift;
  logic             w_lastBit;

  // The first bit of a word uses the live dir input; later bits use the latched copy.
  assign w_dirEff  = (r_state == S_IDLE) ? dir : r_dir;
  assign w_shift   = w_dirEff ? {in, r_asm[WIDTH-1:1]} : {r_asm[WIDTH-2:0], in};
  assign w_lastBit = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_asm      <= '0;
      r_cnt      <= '0;
      r_dir      <= 1'b0;
      r_outData  <= '0;
      r_outValid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_asm      <= w_asmNext;
      r_cnt      <= w_cntNext;
      r_dir      <= w_dirNext;
      r_outData  <= w_outDataNext;
      r_outValid <= w_outValidNext;
      r_overrun  <= w_overrunNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_asmNext      = r_asm;
    w_cntNext      = r_cnt;
    w_dirNext      = r_dir;
    w_outDataNext  = r_outData;
    w_outValidNext = r_outValid;
    w_overrunNext  = r_overrun;

    if (r_outValid && out_ready) begin
      w_outValidNext = 1'b0;
    end

    if (flush) begin
      w_stateNext   = S_IDLE;
      w_asmNext     = '0;
      w_cntNext     = '0;
      w_overrunNext = 1'b0;
    end else if (in_valid) begin
      unique case (r_state)
        S_IDLE: begin
          w_dirNext   = dir;
          w_asmNext   = w_shift;
          w_cntNext   = CW'(1);
          w_stateNext = S_COLLECT;
        end
        S_COLLECT: begin
          if (w_lastBit) begin
            // A completed word may replace one being consumed on this same edge.
            w_stateNext = S_IDLE;
            w_asmNext   = '0;
            w_cntNext   = '0;
            if (!r_outValid || out_ready) begin
              w_outDataNext  = w_shift;
              w_outValidNext = 1'b1;
            end else begin
              w_overrunNext = 1'b1;
            end
          end else begin
            w_asmNext = w_shift;
            w_cntNext = r_cnt + CW'(1);
          end
        end
        default: begin
          w_stateNext = S_IDLE;
        end
      endcase
    end
  end

  assign out_data  = r_outData;
  assign out_valid = r_outValid;
  assign bit_cnt   = r_cnt;
  assign busy      = (r_cnt != '0);
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_bi_deser.sv
// Randomized and directed bench for bi_deser: a bit-list reference model feeds
// a scoreboard queue that a negedge monitor drains on every output transfer.
module tb_bi_deser;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk;
  logic          reset;
  logic          in;
  logic          in_valid;
  logic          dir;
  logic          flush;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic [CW-1:0] bit_cnt;
  logic          busy;
  logic          overrun;

  int checks = 0;
  int errors = 0;
  bit monEn  = 0;

  logic [W-1:0] sbQ[$];
  logic         bits[$];
  logic         mDir;
  logic         mValid;
  logic [W-1:0] mData;
  logic         mOver;

  bi_deser #(.WIDTH(W), .CW(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_valid (in_valid),
    .dir      (dir),
    .flush    (flush),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .bit_cnt  (bit_cnt),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Word value follows directly from arrival order: LSB-first puts bit k at k.
  function automatic logic [W-1:0] buildWord(input logic isLsb);
    logic [W-1:0] w;
    w = '0;
    for (int k = 0; k < W; k++) begin
      if (isLsb) w[k] = bits[k];
      else       w[W-1-k] = bits[k];
    end
    return w;
  endfunction

  task automatic modelClear();
    bits.delete();
    sbQ.delete();
    mDir   = 1'b0;
    mValid = 1'b0;
    mData  = '0;
    mOver  = 1'b0;
  endtask

  // Drive one cycle of inputs, then advance the model by that same edge.
  task automatic applyStimulus(input logic b, input logic iv, input logic d,
                               input logic fl, input logic rdy);
    logic [W-1:0] word;
    logic         wasValid;
    in        = b;
    in_valid  = iv;
    dir       = d;
    flush     = fl;
    out_ready = rdy;
    @(posedge clk);
    wasValid = mValid;
    if (wasValid && rdy) mValid = 1'b0;
    if (fl) begin
      bits.delete();
      mOver = 1'b0;
    end else if (iv) begin
      if (bits.size() == 0) mDir = d;
      bits.push_back(b);
      if (bits.size() == W) begin
        word = buildWord(mDir);
        bits.delete();
        if (!wasValid || rdy) begin
          sbQ.push_back(word);
          mData  = word;
          mValid = 1'b1;
        end else begin
          mOver = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    modelClear();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic sendWord(input logic [W-1:0] w, input logic isLsb, input logic rdy);
    for (int k = 0; k < W; k++) begin
      applyStimulus(isLsb ? w[k] : w[W-1-k], 1'b1, isLsb, 1'b0, rdy);
    end
  endtask

  // Monitor: per-cycle state against the model, and every transfer against the scoreboard.
  always @(negedge clk) begin
    if (monEn) begin
      checkOutput("out_valid", out_valid, mValid);
      checkOutput("out_data", out_data, mData);
      checkOutput("bit_cnt", bit_cnt, bits.size());
      checkOutput("busy", busy, bits.size() != 0);
      checkOutput("overrun", overrun, mOver);
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          checkOutput("sb_nonempty", 0, 1);
        end else begin
          checkOutput("xfer_data", out_data, sbQ.pop_front());
        end
      end
    end
  end

  initial begin
    in = 1'b0; in_valid = 1'b0; dir = 1'b0; flush = 1'b0; out_ready = 1'b0;
    reset = 1'b0;
    modelClear();
    monEn = 1;
    doReset();

    // Reset values held through idle cycles
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_bit_cnt", bit_cnt, 0);

    // LSB-first 1,0,1,1 -> 4'b1101
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("lsb_word", out_data, 4'hD);
    checkOutput("lsb_valid", out_valid, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("lsb_valid_drop", out_valid, 0);

    // MSB-first 1,0,1,1 with dir wiggling mid-word -> 4'b1011
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("msb_cnt1", bit_cnt, 1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("msb_cnt2", bit_cnt, 2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("msb_cnt3", bit_cnt, 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("msb_cnt0", bit_cnt, 0);
    checkOutput("msb_word", out_data, 4'hB);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun: 0xA held, 0x5 dropped, then transfer and flush
    sendWord(4'hA, 1'b0, 1'b0);
    sendWord(4'h5, 1'b0, 1'b0);
    checkOutput("ovr_data", out_data, 4'hA);
    checkOutput("ovr_flag", overrun, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_xfer_valid", out_valid, 0);
    checkOutput("ovr_sticky", overrun, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("ovr_flush", overrun, 0);

    // Completion of 0xC on the same edge that consumes 0x3
    sendWord(4'h3, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("sim_hold", out_data, 4'h3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("sim_valid", out_valid, 1);
    checkOutput("sim_data", out_data, 4'hC);
    checkOutput("sim_ovr", overrun, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Flush with a bit present after 2 bits, then 0,1,1,0 MSB-first
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_cnt", bit_cnt, 0);
    sendWord(4'h6, 1'b0, 1'b1);
    checkOutput("flush_word", out_data, 4'h6);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word discards the partial word
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    doReset();
    checkOutput("rstmid_cnt", bit_cnt, 0);
    checkOutput("rstmid_valid", out_valid, 0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic, including mid-word dir noise and occasional flush
    for (int k = 0; k < 2000; k++) begin
      applyStimulus($urandom_range(1, 0), $urandom_range(3, 0) != 0,
                    $urandom_range(1, 0), $urandom_range(31, 0) == 0,
                    $urandom_range(9, 0) < 6);
    end

    // Drain whatever is still held
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("sb_drained", sbQ.size(), 0);

    @(negedge clk);
    monEn = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bi_deser.md
# bi_deser

Serial-to-parallel receiver for the bidirectional shift-register link. It collects `WIDTH` serial bits, either LSB-first or MSB-first, and reassembles them into a word. The word is presented on a one-entry output register with a valid/ready handshake. It sits on the far end of the serial line from the bi-directional shifter and hands words to the downstream consumer.

## Interface
- `WIDTH`, 4: word length in bits; legal range is 2 or more.
- `CW`, $clog2(WIDTH+1): width of the bit counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; the block is held in reset while low.
- `in` in 1: serial data bit.
- `in_valid` in 1: qualifies `in`; one bit is consumed per cycle in which it is high.
- `dir` in 1: 1 = LSB-first stream, 0 = MSB-first stream. Sampled only on the first bit of a word.
- `flush` in 1: synchronous abort of the partial word.
- `out_ready` in 1: consumer accepts `out_data` when high together with `out_valid`.
- `out_data` out WIDTH: assembled word.
- `out_valid` out 1: `out_data` holds an unconsumed word.
- `bit_cnt` out CW: number of bits collected into the current partial word (0 to WIDTH-1).
- `busy` out 1: high while `bit_cnt` != 0.
- `overrun` out 1: sticky; set when a completed word is dropped. Cleared only by `flush` or reset.

## Operation
- Reset (`reset` low, asynchronous):
  - Assembly register = 0, `bit_cnt` = 0, latched direction = 0.
  - `out_data` = 0, `out_valid` = 0, `overrun` = 0.
- Two states, derived from `bit_cnt`:
  - IDLE (`bit_cnt` = 0): waiting for the first bit.
  - COLLECT (`bit_cnt` 1 to WIDTH-1): partial word in progress.
- First bit of a word (`in_valid` high in IDLE):
  - `dir` is latched and governs the whole word.
  - Changes on `dir` during COLLECT are ignored.
- Assembly, per accepted bit:
  - Latched dir = 1: assembly register shifts right and `in` enters bit WIDTH-1. After WIDTH bits, the first received bit sits at bit 0.
  - Latched dir = 0: assembly register shifts left and `in` enters bit 0. After WIDTH bits, the first received bit sits at bit WIDTH-1.
  - `bit_cnt` increments; it wraps to 0 on the WIDTH-th bit (word complete).
- Word complete, evaluated on the edge that samples bit WIDTH:
  - If `out_valid` = 0, or `out_ready` = 1 in the same cycle: the assembled word loads `out_data` and `out_valid` = 1.
  - Otherwise: the new word is discarded, `out_data` is unchanged, and `overrun` is set.
- Handshake:
  - A transfer occurs on any edge where `out_valid` and `out_ready` are both high.
  - After a transfer with no simultaneous completion, `out_valid` = 0 and `out_data` holds its last value.
  - `out_data` is stable while `out_valid` is high and no transfer occurs.
- `flush`:
  - Clears `bit_cnt`, the assembly register and `overrun`.
  - Does not touch `out_data` or `out_valid`.
  - Has priority over `in_valid` in the same cycle; that bit is dropped.
- `in_valid` low: no state change in assembly; the handshake still proceeds.

## Timing
- Latency: `out_valid` rises on the edge that samples the WIDTH-th bit. The word is visible in the cycle after that bit was presented.
- Maximum throughput is one bit per cycle, sustained indefinitely, provided the consumer accepts each word within WIDTH cycles.
- Completion and transfer in the same cycle: the old word is consumed, the new word is loaded, `out_valid` stays 1, and no overrun occurs.
- Reset asserted mid-word or with `out_valid` high: all state is lost immediately; there is no partial output.
- Release of `reset` is synchronous to `clk` at system level. The first bit can be accepted on the first edge after release.
- `busy` and `bit_cnt` are registered and are not combinational from `in_valid`.

## Test plan
- **Reset values:** reset, then release with `in_valid` low for 5 cycles -> `out_valid` = 0, `out_data` = 0, `bit_cnt` = 0, `overrun` = 0 throughout.
- **LSB-first:** `dir` = 1, bits 1,0,1,1 on consecutive cycles with `out_ready` = 1 -> `out_data` = 4'b1101 and `out_valid` high for exactly one cycle, starting after the 4th bit.
- **MSB-first with direction change:** `dir` = 0, bits 1,0,1,1; `dir` toggled mid-word -> `out_data` = 4'b1011. `bit_cnt` reads 1,2,3 and then 0.
- **Overrun:** `out_ready` = 0, two back-to-back words 0xA then 0x5 -> `out_data` stays 0xA, `overrun` = 1. Raising `out_ready` transfers 0xA. A subsequent `flush` clears `overrun`.
- **Simultaneous complete and accept:** `out_valid` holding 0x3, `out_ready` = 1 on the edge that completes 0xC -> `out_valid` stays 1, `out_data` = 0xC, `overrun` = 0.
- **Abort cases:**
  - `flush` together with `in_valid` after 2 bits, then 4 bits 0,1,1,0 (`dir` = 0) -> only 4'b0110 is delivered.
  - `reset` pulsed low after 3 bits -> no word is delivered and `bit_cnt` = 0.
